// File: rtl/irq_controller_if.sv
// irq_controller_if: peripheral bus connection between a bus master and the
// interrupt controller.
//
// Ports carried:
//   addr   [3:0]          byte offset inside the 16-byte register window
//   w_rb                  1 = write, 0 = read
//   acc    [ACC_W-1:0]    access size: 0 byte, 1 half, 2 word
//   wdata  [BUS_WIDTH-1:0] write data
//   req                   one-cycle access request from the master
//   rdata  [BUS_WIDTH-1:0] read data from the slave, 0 outside a response
//   resp                  one-cycle completion from the slave
//   fault                 access error, only asserted together with resp
//
// Handshake: the master holds req high for exactly one clock per access with
// addr/w_rb/acc/wdata stable; the slave always accepts and answers with resp
// high for exactly one cycle after the sampling edge, with fault and rdata
// valid in that same cycle. A new req may be presented during a resp cycle.
interface irq_controller_if #(
    parameter int BUS_WIDTH = 32,
    parameter int ACC_W     = 2
);
    logic [3:0]           addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 req;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 resp;
    logic                 fault;

    modport master (
        output addr, w_rb, acc, wdata, req,
        input  rdata, resp, fault
    );

    modport slave (
        input  addr, w_rb, acc, wdata, req,
        output rdata, resp, fault
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: level-to-edge interrupt aggregator.
//
// Rising edges on src[] latch into pending bits; pending bits gated by the
// per-source enables and the global enable drive irq. Firmware reads CLAIM to
// get (and clear) the lowest-numbered active source.
//
// Register map (word accesses only):
//   0x0 PEND  read pending, write-1-to-clear
//   0x4 EN    per-source enable, R/W
//   0x8 CLAIM read {valid, 26'b0, id[4:0]} and clear that pending bit; RO
//   0xC CFG   bit0 = GIE, R/W
//
// Ports:
//   clk    system clock
//   rstn   asynchronous active-low reset
//   src    peripheral interrupt levels, synchronous to clk
//   bus    peripheral bus slave (irq_controller_if.slave)
//   irq    interrupt request to the core
module irq_controller #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_SRC-1:0] src,
    irq_controller_if.slave  bus,
    output logic             irq
);
    localparam int         BUS_WIDTH = 32;
    localparam logic [1:0] ACC_WORD  = 2'd2;
    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_EN    = 2'd1;
    localparam logic [1:0] REG_CLAIM = 2'd2;
    localparam logic [1:0] REG_CFG   = 2'd3;

    logic [N_SRC-1:0]     pend_q, pend_d;
    logic [N_SRC-1:0]     en_q, en_d;
    logic                 gie_q, gie_d;
    logic [N_SRC-1:0]     src_q, src_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 resp_q, resp_d;
    logic                 fault_q, fault_d;

    logic [N_SRC-1:0]     src_rise;
    logic [N_SRC-1:0]     active;
    logic                 claim_hit;
    logic [4:0]           claim_id;
    logic [N_SRC-1:0]     claim_mask;
    logic [1:0]           reg_sel;
    logic                 acc_fault;
    logic                 do_rd;
    logic                 do_wr;
    logic [BUS_WIDTH-1:0] rd_val;

    // Only the low N_SRC bits of wdata carry register content.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.wdata[BUS_WIDTH-1:N_SRC]};

    assign src_rise = src & ~src_q;
    assign active   = pend_q & en_q;
    assign reg_sel  = bus.addr[3:2];

    // Lowest active index wins: scan downward so the last hit is the lowest.
    always_comb begin
        claim_hit  = 1'b0;
        claim_id   = '0;
        claim_mask = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_hit  = 1'b1;
                claim_id   = 5'(i);
                claim_mask = '0;
                claim_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        acc_fault = (bus.acc != ACC_WORD) || (bus.addr[1:0] != 2'b00) ||
                    (bus.w_rb && (reg_sel == REG_CLAIM));
        do_rd = bus.req && !acc_fault && !bus.w_rb;
        do_wr = bus.req && !acc_fault &&  bus.w_rb;
    end

    // Read data is taken from register state before this edge's updates.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_PEND:  rd_val = {{(BUS_WIDTH - N_SRC){1'b0}}, pend_q};
            REG_EN:    rd_val = {{(BUS_WIDTH - N_SRC){1'b0}}, en_q};
            REG_CLAIM: rd_val = claim_hit ? {1'b1, 26'b0, claim_id} : '0;
            REG_CFG:   rd_val = {{(BUS_WIDTH - 1){1'b0}}, gie_q};
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        en_d    = en_q;
        gie_d   = gie_q;
        src_d   = src;
        rdata_d = '0;
        resp_d  = bus.req;
        fault_d = bus.req && acc_fault;

        if (do_wr) begin
            case (reg_sel)
                REG_PEND: pend_d = pend_q & ~bus.wdata[N_SRC-1:0];
                REG_EN:   en_d   = bus.wdata[N_SRC-1:0];
                REG_CFG:  gie_d  = bus.wdata[0];
                default:  ;
            endcase
        end

        if (do_rd) begin
            rdata_d = rd_val;
            if (reg_sel == REG_CLAIM) begin
                pend_d = pend_q & ~claim_mask;
            end
        end

        // A new edge overrides any clear applied in the same cycle.
        pend_d = pend_d | src_rise;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= '0;
            en_q    <= '0;
            gie_q   <= 1'b0;
            src_q   <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            gie_q   <= gie_d;
            src_q   <= src_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            fault_q <= fault_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.resp  = resp_q;
    assign bus.fault = fault_q;
    assign irq       = gie_q && (|active);
endmodule
